// File: rtl/ver_stream_arbiter.sv
// Round-robin frame arbiter: shares one streaming bus between INPUTS sources, locked SOF..EOF.
// Latency: 1 cycle request-to-grant; 0 cycles data/ready path while locked.
// Backpressure: TX_DST_RDY is routed to the granted source only; all other sources see ready low.
//
// Ports:
//   clk_i, rst_i                 clock (rising edge), asynchronous active-high reset
//   rx_data_i/sof/eof/src_rdy_i  per-port source stream, port i data at [i*DATA_WIDTH +: DATA_WIDTH]
//   rx_dst_rdy_o                 per-port ready back to the sources
//   tx_data/sof/eof/src_rdy_o    shared output stream, tx_dst_rdy_i its ready
//   tx_port_o                    index of the granted (or last granted) port
//   busy_o                       high while a frame lock is held
//   cnt_clr_i, cnt_frames_o      per-port completed-frame counters
//
// Optional feature: define VER_STREAM_ARBITER_STATS_EN to build the per-port frame counters.
// Without it cnt_frames_o is tied to zero and cnt_clr_i is ignored.

module ver_stream_arbiter #(
    parameter int INPUTS     = 4,
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [INPUTS*DATA_WIDTH-1:0]   rx_data_i,
    input  logic [INPUTS-1:0]              rx_sof_i,
    input  logic [INPUTS-1:0]              rx_eof_i,
    input  logic [INPUTS-1:0]              rx_src_rdy_i,
    output logic [INPUTS-1:0]              rx_dst_rdy_o,
    output logic [DATA_WIDTH-1:0]          tx_data_o,
    output logic                           tx_sof_o,
    output logic                           tx_eof_o,
    output logic                           tx_src_rdy_o,
    input  logic                           tx_dst_rdy_i,
    output logic [$clog2(INPUTS)-1:0]      tx_port_o,
    output logic                           busy_o,
    input  logic                           cnt_clr_i,
    output logic [INPUTS*CNT_WIDTH-1:0]    cnt_frames_o
);

    localparam int PW = $clog2(INPUTS);

    typedef enum logic {
        ST_IDLE,
        ST_LOCK
    } state_t;

    state_t          state_q;
    logic [PW-1:0]   grant_q;
    logic [PW-1:0]   last_q;

    logic [INPUTS-1:0] eligible;
    logic            grant_vld_d;
    logic [PW-1:0]   grant_d;
    logic            eof_xfer;

    // Only a frame start may win arbitration; a valid word without SOF is left stalled.
    assign eligible = rx_src_rdy_i & rx_sof_i;

    // Round-robin search starting one past the last winner, wrapping around.
    always_comb begin
        grant_vld_d = 1'b0;
        grant_d     = '0;
        for (int k = 1; k <= INPUTS; k++) begin
            int j;
            j = int'(last_q) + k;
            if (j >= INPUTS) begin
                j = j - INPUTS;
            end
            if (!grant_vld_d && eligible[PW'(j)]) begin
                grant_vld_d = 1'b1;
                grant_d     = PW'(j);
            end
        end
    end

    // Output mux: the granted source is wired straight through while locked.
    always_comb begin
        tx_data_o    = '0;
        tx_sof_o     = 1'b0;
        tx_eof_o     = 1'b0;
        tx_src_rdy_o = 1'b0;
        rx_dst_rdy_o = '0;
        if (state_q == ST_LOCK) begin
            tx_data_o             = rx_data_i[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
            tx_sof_o              = rx_sof_i[grant_q];
            tx_eof_o              = rx_eof_i[grant_q];
            tx_src_rdy_o          = rx_src_rdy_i[grant_q];
            rx_dst_rdy_o[grant_q] = tx_dst_rdy_i;
        end
    end

    assign eof_xfer  = tx_src_rdy_o & tx_dst_rdy_i & tx_eof_o;
    assign busy_o    = (state_q == ST_LOCK);
    assign tx_port_o = grant_q;

    // last_q resets to the top port so port 0 has first priority out of reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= PW'(INPUTS - 1);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_vld_d) begin
                        grant_q <= grant_d;
                        last_q  <= grant_d;
                        state_q <= ST_LOCK;
                    end
                end
                ST_LOCK: begin
                    // Framing is not checked: only an accepted EOF releases the lock.
                    if (eof_xfer) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef VER_STREAM_ARBITER_STATS_EN
    logic [CNT_WIDTH-1:0] cnt_q [INPUTS];

    // Clear takes priority over a same-cycle increment; counters wrap naturally.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < INPUTS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < INPUTS; i++) begin
                if (cnt_clr_i) begin
                    cnt_q[i] <= '0;
                end else if (eof_xfer && (grant_q == PW'(i))) begin
                    cnt_q[i] <= cnt_q[i] + CNT_WIDTH'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < INPUTS; g++) begin : g_cnt_out
        assign cnt_frames_o[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q[g];
    end
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr_i;
    assign cnt_frames_o   = '0;
`endif

endmodule

// File: tb/tb_ver_stream_arbiter.sv
// Self-checking bench for ver_stream_arbiter: arbitration vector table plus
// scoreboarded multi-cycle scenarios (single port, fairness, backpressure, reset, stats).
module tb_ver_stream_arbiter;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int CW = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [N*DW-1:0]   rx_data;
    logic [N-1:0]      rx_sof, rx_eof, rx_src_rdy, rx_dst_rdy;
    logic [DW-1:0]     tx_data;
    logic              tx_sof, tx_eof, tx_src_rdy, tx_dst_rdy;
    logic [1:0]        tx_port;
    logic              busy;
    logic              cnt_clr;
    logic [N*CW-1:0]   cnt_frames;

    always #5 clk = ~clk;

    ver_stream_arbiter #(.INPUTS(N), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .rx_data_i    (rx_data),
        .rx_sof_i     (rx_sof),
        .rx_eof_i     (rx_eof),
        .rx_src_rdy_i (rx_src_rdy),
        .rx_dst_rdy_o (rx_dst_rdy),
        .tx_data_o    (tx_data),
        .tx_sof_o     (tx_sof),
        .tx_eof_o     (tx_eof),
        .tx_src_rdy_o (tx_src_rdy),
        .tx_dst_rdy_i (tx_dst_rdy),
        .tx_port_o    (tx_port),
        .busy_o       (busy),
        .cnt_clr_i    (cnt_clr),
        .cnt_frames_o (cnt_frames)
    );

    int    n_cmp = 0;
    int    n_bad = 0;
    string scen  = "reset";

    typedef struct { logic [63:0] data; logic sof; logic eof; } beat_t;
    typedef struct { int cyc; int port; logic [63:0] data; logic sof; logic eof; } exp_t;
    typedef struct { int from; int to; int port; } win_t;
    typedef struct { logic [3:0] v; logic [3:0] s; int exp; } vec_t;

    beat_t src [N][32];
    int    scnt [N];
    int    sidx [N];
    bit    adv  [N];
    exp_t  sb [$];
    win_t  wins [$];
    bit    bp_mode;
    int    clr_cyc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s/%s: got %0h required %0h", scen, name, act, exp);
        end
    endtask

    function automatic logic [63:0] data_of(input int port, input int tag, input int b);
        return 64'hC0DE_0000_0000_0000 | (64'(tag) << 16) | (64'(port) << 8) | 64'(b);
    endfunction

    task automatic drive_idle();
        rx_data    = '0;
        rx_sof     = '0;
        rx_eof     = '0;
        rx_src_rdy = '0;
        tx_dst_rdy = 1'b1;
        cnt_clr    = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        drive_idle();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic clear_src();
        for (int p = 0; p < N; p++) begin
            scnt[p] = 0;
            sidx[p] = 0;
            adv[p]  = 1'b0;
        end
        sb.delete();
        wins.delete();
        bp_mode = 1'b0;
        clr_cyc = -1;
    endtask

    // Queue a frame on a source and push the beats the DUT must forward:
    // lock held from lock_start, beat b accepted at cycle first + b*step.
    task automatic add_frame(input int port, input int len, input int nexp,
                             input int lock_start, input int first, input int step, input int tag);
        logic [63:0] d;
        for (int b = 0; b < len; b++) begin
            d = data_of(port, tag, b);
            src[port][scnt[port]] = '{d, (b == 0), (b == len - 1)};
            scnt[port]++;
            if (b < nexp) begin
                sb.push_back('{first + b*step, port, d, (b == 0), (b == len - 1)});
            end
        end
        wins.push_back('{lock_start, first + (nexp - 1)*step, port});
    endtask

    task automatic run(input int n);
        exp_t e;
        logic busy_e;
        int   port_e;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            for (int p = 0; p < N; p++) begin
                if (adv[p]) sidx[p]++;
                adv[p] = 1'b0;
                if (sidx[p] < scnt[p]) begin
                    rx_data[p*DW +: DW] = src[p][sidx[p]].data;
                    rx_sof[p]           = src[p][sidx[p]].sof;
                    rx_eof[p]           = src[p][sidx[p]].eof;
                    rx_src_rdy[p]       = 1'b1;
                end else begin
                    rx_data[p*DW +: DW] = '0;
                    rx_sof[p]           = 1'b0;
                    rx_eof[p]           = 1'b0;
                    rx_src_rdy[p]       = 1'b0;
                end
            end
            tx_dst_rdy = bp_mode ? (c % 2 == 0) : 1'b1;
            cnt_clr    = (c == clr_cyc);
            #1;
            busy_e = 1'b0;
            port_e = 0;
            foreach (wins[w]) begin
                if (c >= wins[w].from && c <= wins[w].to) begin
                    busy_e = 1'b1;
                    port_e = wins[w].port;
                end
            end
            chk("busy", 64'(busy), 64'(busy_e));
            chk("rx_dst_rdy", 64'(rx_dst_rdy), busy_e ? (64'(tx_dst_rdy) << port_e) : 64'd0);
            if (busy_e) chk("tx_port", 64'(tx_port), 64'(port_e));
            if (tx_src_rdy && tx_dst_rdy) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL %s/unexpected_xfer: got transfer at cycle %0d required none", scen, c);
                end else begin
                    e = sb.pop_front();
                    chk("xfer_cycle", 64'(c), 64'(e.cyc));
                    chk("xfer_port", 64'(tx_port), 64'(e.port));
                    chk("xfer_data", tx_data, e.data);
                    chk("xfer_sof", 64'(tx_sof), 64'(e.sof));
                    chk("xfer_eof", 64'(tx_eof), 64'(e.eof));
                end
            end
            for (int p = 0; p < N; p++) adv[p] = rx_src_rdy[p] & rx_dst_rdy[p];
        end
        chk("beats_left", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        vec_t tbl [9];
        logic [31:0] exp_cnt4;

        rst = 1'b1;
        drive_idle();
        clear_src();
        repeat (2) @(negedge clk);
        #1;
        chk("busy", 64'(busy), 64'd0);
        chk("tx_src_rdy", 64'(tx_src_rdy), 64'd0);
        chk("tx_sof_eof", 64'({tx_sof, tx_eof}), 64'd0);
        chk("tx_data", tx_data, 64'd0);
        chk("rx_dst_rdy", 64'(rx_dst_rdy), 64'd0);
        chk("tx_port", 64'(tx_port), 64'd0);
        chk("cnt_frames", cnt_frames[63:0] | cnt_frames[127:64], 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Arbitration table: single-beat frames, expected winner from a fresh reset (last = 3).
        scen = "table";
        tbl[0] = '{4'b1111, 4'b1111, 0};
        tbl[1] = '{4'b1111, 4'b1111, 1};
        tbl[2] = '{4'b0101, 4'b0101, 2};
        tbl[3] = '{4'b0101, 4'b0101, 0};
        tbl[4] = '{4'b1000, 4'b0000, -1};  // valid without SOF: nobody eligible
        tbl[5] = '{4'b1001, 4'b1000, 3};   // port 0 valid without SOF stays stalled
        tbl[6] = '{4'b0011, 4'b0011, 0};
        tbl[7] = '{4'b0010, 4'b0010, 1};
        tbl[8] = '{4'b0001, 4'b0001, 0};
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            rx_src_rdy = tbl[i].v;
            rx_sof     = tbl[i].s;
            rx_eof     = 4'hF;
            tx_dst_rdy = 1'b1;
            for (int p = 0; p < N; p++) rx_data[p*DW +: DW] = {16'hA5A5, 16'(i), 32'(p)};
            #1;
            chk("idle_busy", 64'(busy), 64'd0);
            chk("idle_rx_dst_rdy", 64'(rx_dst_rdy), 64'd0);
            chk("idle_tx_src_rdy", 64'(tx_src_rdy), 64'd0);
            @(negedge clk);
            #1;
            if (tbl[i].exp >= 0) begin
                chk("grant_busy", 64'(busy), 64'd1);
                chk("grant_port", 64'(tx_port), 64'(tbl[i].exp));
                chk("grant_rx_dst_rdy", 64'(rx_dst_rdy), 64'd1 << tbl[i].exp);
                chk("grant_data", tx_data, {16'hA5A5, 16'(i), 32'(tbl[i].exp)});
                chk("grant_sof_eof", 64'({tx_sof, tx_eof, tx_src_rdy}), 64'b111);
            end else begin
                chk("nogrant_busy", 64'(busy), 64'd0);
                chk("nogrant_rx_dst_rdy", 64'(rx_dst_rdy), 64'd0);
            end
        end

        scen = "single";
        apply_reset();
        clear_src();
        add_frame(2, 3, 3, 1, 1, 1, 1);
        run(5);

        scen = "fairness";
        apply_reset();
        clear_src();
        for (int k = 0; k < 8; k++) add_frame(k % 4, 2, 2, 3*k + 1, 3*k + 1, 1, 16 + k);
        run(26);

        scen = "backpressure";
        apply_reset();
        clear_src();
        bp_mode = 1'b1;
        add_frame(1, 4, 4, 1, 2, 2, 40);
        add_frame(2, 1, 1, 10, 10, 1, 41);
        run(11);

        scen = "reset_mid";
        apply_reset();
        clear_src();
        add_frame(1, 5, 2, 1, 1, 1, 50);
        run(3);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("busy", 64'(busy), 64'd0);
        chk("tx_src_rdy", 64'(tx_src_rdy), 64'd0);
        chk("tx_eof", 64'(tx_eof), 64'd0);
        chk("rx_dst_rdy", 64'(rx_dst_rdy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        drive_idle();
        clear_src();
        add_frame(0, 1, 1, 1, 1, 1, 52);
        add_frame(1, 2, 2, 3, 3, 1, 51);
        run(6);

        scen = "stats";
`ifdef VER_STREAM_ARBITER_STATS_EN
        exp_cnt4 = 32'd4;
`else
        exp_cnt4 = 32'd0;
`endif
        apply_reset();
        clear_src();
        for (int k = 0; k < 4; k++) add_frame(3, 1, 1, 2*k + 1, 2*k + 1, 1, 60 + k);
        run(8);
        @(negedge clk);
        drive_idle();
        #1;
        chk("cnt_port3", 64'(cnt_frames[3*CW +: CW]), 64'(exp_cnt4));
        chk("cnt_port0_2", cnt_frames[63:0] | 64'(cnt_frames[95:64]), 64'd0);
        clear_src();
        clr_cyc = 1;
        add_frame(3, 1, 1, 1, 1, 1, 64);
        run(3);
        @(negedge clk);
        drive_idle();
        #1;
        chk("cnt_after_clr", cnt_frames[63:0] | cnt_frames[127:64], 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
